// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths,
// FSM state encoding and small arithmetic helpers used around the adder.
package multdiv_unit_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Magnitude of a signed value; INT_MIN maps to 0x80000000 read as unsigned.
  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    if (v[31]) return ~v + 32'd1;
    return v;
  endfunction

  // Carry out of bit 31, reconstructed from the operand and sum MSBs.
  function automatic logic carry32(input logic x_msb, input logic y_msb, input logic s_msb);
    return (x_msb & y_msb) | ((x_msb ^ y_msb) & ~s_msb);
  endfunction

  // Sign of the exact 33-bit sum of two sign-extended 32-bit operands.
  function automatic logic sign33(input logic x_msb, input logic y_msb, input logic s_msb);
    return x_msb ^ y_msb ^ carry32(x_msb, y_msb, s_msb);
  endfunction

endpackage

// File: rtl/adder.sv
// Shared combinational 32-bit adder: out = x + y + sub.
// Subtraction is requested by the caller presenting ~operand on y with sub=1.
module adder (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        sub,
  output logic [31:0] out
);

  assign out = x + y + {31'd0, sub};

endmodule

// File: rtl/multdiv_counter.sv
// Iteration counter for the multiply/divide unit, with synchronous clear,
// count enable and a terminal-count flag at ITER-1. It saturates there.
module multdiv_counter #(
  parameter int ITER  = multdiv_unit_pkg::ITER,
  parameter int CNT_W = multdiv_unit_pkg::CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] count;

  assign last = (count == CNT_W'(ITER - 1));

  // Iteration count: cleared on start/done, advances once per iteration cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply (radix-2 Booth) / divide (restoring on
// magnitudes) unit. One shared adder serves every iteration; the pipeline
// stalls on busy and picks the result up on the result_rdy pulse.
module multdiv_unit #(
  parameter int WIDTH = multdiv_unit_pkg::WIDTH,
  parameter int ITER  = multdiv_unit_pkg::ITER,
  parameter int CNT_W = multdiv_unit_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy
);

  import multdiv_unit_pkg::*;

  state_t state;
  state_t state_next;

  logic start_mult;
  logic start_div;
  logic div_by_zero;

  // Working registers: {hi, lo, qm1} is the Booth product register during a
  // multiply and {R, Q} during a divide; m holds the multiplicand or |divisor|.
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  logic             qm1;
  logic             op_div;
  logic             sign_q;
  logic             div_ovf;
  logic             dz;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_sub;
  logic [WIDTH-1:0] add_out;
  logic             sum_msb;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_shift;

  logic cnt_clear;
  logic cnt_en;
  logic cnt_last;

  assign a_s = operand_a;
  assign b_s = operand_b;

  assign start_mult  = (state == ST_IDLE) && ctrl_mult;
  assign start_div   = (state == ST_IDLE) && ctrl_div && !ctrl_mult;
  assign div_by_zero = start_div && (operand_b == '0);

  assign cnt_clear = start_mult || start_div || (state == ST_DONE);
  assign cnt_en    = (state == ST_MULT) || (state == ST_DIV);

  assign rem_shift = {hi[WIDTH-2:0], lo[WIDTH-1]};

  multdiv_counter #(
    .ITER  (ITER),
    .CNT_W (CNT_W)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .last   (cnt_last)
  );

  adder u_adder (
    .x   (add_x),
    .y   (add_y),
    .sub (add_sub),
    .out (add_out)
  );

  // Booth needs the true 33-bit sign of P_hi +/- M to shift in; the divide
  // needs the no-borrow flag of the trial subtraction (unsigned compare).
  assign sum_msb   = sign33(add_x[WIDTH-1], add_y[WIDTH-1], add_out[WIDTH-1]);
  assign no_borrow = carry32(add_x[WIDTH-1], add_y[WIDTH-1], add_out[WIDTH-1]);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; divide-by-zero skips the iterations entirely.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_mult) begin
          state_next = ST_MULT;
        end else if (start_div) begin
          state_next = div_by_zero ? ST_DONE : ST_DIV;
        end
      end
      ST_MULT, ST_DIV: begin
        if (cnt_last) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Adder operand steering: Booth add/sub, divide trial subtract, and the
  // final quotient negation in DONE.
  always_comb begin
    add_x   = hi;
    add_y   = '0;
    add_sub = 1'b0;
    case (state)
      ST_MULT: begin
        case ({lo[0], qm1})
          2'b01: begin
            add_y = m;
          end
          2'b10: begin
            add_y   = ~m;
            add_sub = 1'b1;
          end
          default: begin
            add_y = '0;
          end
        endcase
      end
      ST_DIV: begin
        add_x   = rem_shift;
        add_y   = ~m;
        add_sub = 1'b1;
      end
      ST_DONE: begin
        add_x   = '0;
        add_y   = ~lo;
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  // Working registers: load on an accepted start, then one iteration per cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      m       <= '0;
      qm1     <= 1'b0;
      op_div  <= 1'b0;
      sign_q  <= 1'b0;
      div_ovf <= 1'b0;
      dz      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_mult) begin
            hi      <= '0;
            lo      <= operand_b;
            m       <= operand_a;
            qm1     <= 1'b0;
            op_div  <= 1'b0;
            sign_q  <= 1'b0;
            div_ovf <= 1'b0;
            dz      <= 1'b0;
          end else if (start_div) begin
            hi      <= '0;
            lo      <= mag32(a_s);
            m       <= mag32(b_s);
            qm1     <= 1'b0;
            op_div  <= 1'b1;
            sign_q  <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            div_ovf <= (operand_a == INT_MIN) && (operand_b == '1);
            dz      <= div_by_zero;
          end
        end
        ST_MULT: begin
          hi  <= {sum_msb, add_out[WIDTH-1:1]};
          lo  <= {add_out[0], lo[WIDTH-1:1]};
          qm1 <= lo[0];
        end
        ST_DIV: begin
          if (no_borrow) begin
            hi <= add_out;
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= rem_shift;
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: busy tracking, result/exception capture, result_rdy pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      result     <= '0;
      exception  <= 1'b0;
      result_rdy <= 1'b0;
    end else begin
      result_rdy <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= start_mult || start_div;
          if (div_by_zero) begin
            result     <= '0;
            exception  <= 1'b1;
            result_rdy <= 1'b1;
          end
        end
        ST_MULT, ST_DIV: begin
          busy <= 1'b1;
        end
        ST_DONE: begin
          if (dz) begin
            busy <= 1'b0;
          end else begin
            busy       <= 1'b1;
            result_rdy <= 1'b1;
            if (op_div) begin
              result    <= sign_q ? add_out : lo;
              exception <= div_ovf;
            end else begin
              result    <= lo;
              exception <= (hi != {WIDTH{lo[WIDTH-1]}});
            end
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: the driver pushes the expected result,
// exception flag and arrival cycle of every accepted operation; a monitor pops
// and compares whenever result_rdy is seen.
module tb_multdiv_unit;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;
  localparam int          LAT     = 33;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy;
  logic [31:0] result;
  logic        exception;
  logic        result_rdy;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [31:0] edges [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  multdiv_unit dut (
    .clock      (clock),
    .reset      (reset),
    .ctrl_mult  (ctrl_mult),
    .ctrl_div   (ctrl_div),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .result     (result),
    .exception  (exception),
    .result_rdy (result_rdy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact signed arithmetic on 64-bit integers.
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'h0) begin
      r = 32'h0;
      e = 1'b1;
    end else if (a == MIN_INT && b == 32'hFFFF_FFFF) begin
      r = MIN_INT;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 200)) - 32'd100;
      2:       return edges[$urandom_range(0, 4)];
      default: return $urandom & 32'h0000_FFFF;
    endcase
  endfunction

  // Called half-way into a cycle; the start is sampled at the next rising edge.
  task automatic issue(input bit is_div, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t e;
    model(is_div, a, b, e.res, e.exc);
    e.cyc  = cyc + 1 + ((is_div && b == 32'h0) ? 0 : LAT);
    e.name = name;
    sb.push_back(e);
    ctrl_mult = !is_div;
    ctrl_div  = is_div;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    #2;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    check({name, ".busy_after_start"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clock);
      #1;
      waited++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.timeout: no result_rdy within %0d cycles", name, waited);
      sb.delete();
    end
    @(posedge clock);
    #2;
    check({name, ".busy_after_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run(input bit is_div, input logic [31:0] a, input logic [31:0] b, input string name);
    issue(is_div, a, b, name);
    wait_done(name);
  endtask

  // Monitor: every result_rdy must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && result_rdy) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_rdy: result_rdy=1 at cycle %0d with nothing outstanding (result=%h)", cyc, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".result"}, result, e.res);
        check({e.name, ".exception"}, {31'd0, exception}, {31'd0, e.exc});
        check({e.name, ".latency_cycle"}, 32'(cyc), 32'(e.cyc));
        check({e.name, ".busy_with_rdy"}, {31'd0, busy}, 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #3;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.exception", {31'd0, exception}, 32'd0);
    check("reset.result_rdy", {31'd0, result_rdy}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #2;

    // Directed cases.
    run(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, "mul_7x-3");
    run(1'b0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    run(1'b0, 32'h8000_0000, 32'h0000_0001, "mul_min_x1");
    run(1'b0, 32'h8000_0000, 32'h8000_0000, "mul_min_x_min");
    run(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, "div_-7/2");
    run(1'b1, 32'd100, 32'd7, "div_100/7");
    run(1'b1, 32'd5, 32'd0, "div_by_zero");
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min/-1");
    run(1'b1, 32'h8000_0000, 32'h0000_0001, "div_min/1");

    // A divide start during a multiply is ignored.
    issue(1'b0, 32'd6, 32'd6, "mul_6x6_busy");
    repeat (9) begin
      @(posedge clock);
      #2;
    end
    ctrl_div  = 1'b1;
    operand_a = 32'd9;
    operand_b = 32'd3;
    @(posedge clock);
    #2;
    ctrl_div = 1'b0;
    wait_done("mul_6x6_busy");

    // Asynchronous reset mid-multiply abandons the operation.
    issue(1'b0, 32'd1234, 32'd5678, "mul_reset");
    repeat (14) begin
      @(posedge clock);
      #2;
    end
    reset = 1'b1;
    #1;
    check("midreset.busy", {31'd0, busy}, 32'd0);
    check("midreset.result", result, 32'd0);
    check("midreset.exception", {31'd0, exception}, 32'd0);
    check("midreset.result_rdy", {31'd0, result_rdy}, 32'd0);
    sb.delete();
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #2;
    end
    check("after_reset.result_held", result, 32'd0);
    run(1'b0, 32'd2, 32'd3, "mul_2x3_after_reset");

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 24; i++) begin
      bit          op;
      logic [31:0] a;
      logic [31:0] b;
      int          gap;
      op  = 1'($urandom_range(0, 1));
      a   = pick();
      b   = pick();
      gap = $urandom_range(0, 2);
      run(op, a, b, $sformatf("rand%0d_%s", i, op ? "div" : "mul"));
      repeat (gap) begin
        @(posedge clock);
        #2;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative 32-bit signed multiply/divide unit, sitting beside the ALU in the execute stage.
- Drives operands and the add/sub select into one shared instance of the team's combinational 32-bit `adder` (ports x, y, sub, out) and consumes its sum each cycle.
- Produces a 32-bit result plus an exception flag; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported because the adder is fixed at 32 bits.
- ITER, 32, number of iteration cycles per operation.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > ITER.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ctrl_mult  in  1  single-cycle start pulse for multiply
- ctrl_div  in  1  single-cycle start pulse for divide
- operand_a  in  32  multiplicand / dividend, signed; sampled only on an accepted start
- operand_b  in  32  multiplier / divisor, signed; sampled only on an accepted start
- busy  out  1  high from the cycle after an accepted start through the cycle result_rdy is high
- result  out  32  product low word or quotient; held until the next accepted start
- exception  out  1  overflow, divide-by-zero, or INT_MIN/-1; valid while result_rdy=1, then held
- result_rdy  out  1  one-cycle pulse marking a valid result

Behaviour:
- Reset (asynchronous, any state): state=IDLE; counter=0; busy=0; result=0; exception=0; result_rdy=0; working registers cleared. Reset mid-operation abandons the operation and emits no result_rdy.
- States: IDLE, MULT, DIV, DONE.
  - IDLE: on an accepted start, go to MULT or DIV.
  - MULT/DIV: go to DONE when counter reaches ITER-1.
  - DONE: lasts one cycle, then IDLE.
- Start acceptance: a start is accepted only in IDLE. A start in MULT/DIV/DONE is ignored, with no effect on state or outputs. If ctrl_mult and ctrl_div are high together, multiply wins.
- Latency: start accepted at edge N → result_rdy=1 in the cycle following edge N+ITER+1 (33 cycles after the start cycle), for exactly one cycle. Exception: divide-by-zero takes the short path described below.
- Multiply (radix-2 Booth):
  - 65-bit product register {P_hi[31:0], P_lo[31:0], q-1}, initialised to {0, operand_b, 0}; multiplicand M = operand_a.
  - Each cycle, examine {P_lo[0], q-1}:
    - 01: adder computes P_hi+M (sub=0, y=M).
    - 10: adder computes P_hi-M (sub=1, y=~M).
    - 00/11: adder computes P_hi+0.
  - Then arithmetic-shift the whole register right by 1.
  - Result = P_lo. exception=1 iff P_hi is not all copies of P_lo[31] (signed 32-bit overflow).
- Divide (restoring, on magnitudes):
  - At start, latch sign_q = a[31]^b[31]; |a| and |b| are formed via the adder (0 - x) in the start cycle path or an explicit negate.
  - Each cycle: shift {R, Q} left by 1, trial R-|b| through the adder (sub=1, y=~|b|). If the sum is non-negative, R=sum and Q[0]=1; otherwise restore R and set Q[0]=0.
  - Result = sign_q ? -Q : Q. The quotient truncates toward zero; the remainder is discarded.
  - Divide by zero: result=0, exception=1, result_rdy pulses one cycle after the start (IDLE→DONE directly); busy is high for that one cycle only.
  - 0x80000000 / -1: result=0x80000000, exception=1, normal latency.
- Counter:
  - Counts 0..ITER-1 in MULT/DIV.
  - Cleared on start and in DONE.
  - Never wraps during an operation.
- All outputs are registered; operand changes after the start cycle have no effect.

Decomposition:
- Shared package: state encoding (IDLE/MULT/DIV/DONE), constants WIDTH=32, ITER=32, CNT_W=6, INT_MIN=32'h80000000.
- Single sub-module: `multdiv_counter`, a CNT_W-bit counter with clear/enable and a terminal-count flag at ITER-1.
- The adder is instantiated once and shared by multiply and divide.

Test Plan:
- mult 7 × -3 (0x00000007, 0xFFFFFFFD) → result_rdy exactly 33 cycles after start, result=0xFFFFFFEB, exception=0.
- mult 0x00010000 × 0x00010000 → result=0x00000000, exception=1; mult 0x80000000 × 1 → 0x80000000, exception=0.
- div -7 / 2 → result=0xFFFFFFFD (-3), exception=0; div 100 / 7 → 14.
- div 5 / 0 → result_rdy one cycle after start, result=0, exception=1; div 0x80000000 / 0xFFFFFFFF → result=0x80000000, exception=1.
- start mult 6×6, pulse ctrl_div with 9/3 ten cycles later → div ignored; result=36 at normal latency, with only one result_rdy pulse.
- reset asserted mid-multiply at cycle 15 → all outputs 0 immediately (asynchronous); no result_rdy follows. A new mult 2×3 after reset release → result=6.
